// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared types and constants for the multiplier sequencer
// Purpose: state encoding, datapath widths and default watchdog settings.
// Ports: none (package).
package mul_seq_pkg;

   localparam int OP_W        = 64;
   localparam int RES_W       = 128;
   localparam int TIMEOUT_DEF = 200;
   localparam int CNT_W_DEF   = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2,
      ST_OUT   = 2'd3
   } state_e;

endpackage

// File: rtl/mul_sequencer_if.sv
// rtl/mul_sequencer_if.sv - operand/result streams and multiplier link bundle
// Purpose: groups the upstream operand handshake, the multiplier control
//          link and the downstream result handshake.
// Ports:   slave  = sequencer view (accepts operands, drives multiplier,
//                   presents results)
//          master = environment view (source, multiplier, sink)
interface mul_sequencer_if;
   import mul_seq_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  in_multiplier;
   logic [OP_W-1:0]  in_multiplicand;

   logic [OP_W-1:0]  mul_multiplier;
   logic [OP_W-1:0]  mul_multiplicand;
   logic             mul_op_start;
   logic             mul_op_clear;
   logic             mul_op_done;
   logic [RES_W-1:0] mul_result;

   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] out_result;
   logic             out_err;

   modport slave (
      input  in_valid, in_multiplier, in_multiplicand,
      input  mul_op_done, mul_result, out_ready,
      output in_ready, mul_multiplier, mul_multiplicand,
      output mul_op_start, mul_op_clear,
      output out_valid, out_result, out_err
   );

   modport master (
      output in_valid, in_multiplier, in_multiplicand,
      output mul_op_done, mul_result, out_ready,
      input  in_ready, mul_multiplier, mul_multiplicand,
      input  mul_op_start, mul_op_clear,
      input  out_valid, out_result, out_err
   );

endinterface

// File: rtl/mul_seq_watchdog.sv
// rtl/mul_seq_watchdog.sv - run-time watchdog counter for the sequencer
// Purpose: counts cycles while enabled; expire flags count == TIMEOUT-1.
// Ports:   clk, reset_n (async active-low), clr (sync zero, wins over en),
//          en (increment), expire (registered-count compare).
module mul_seq_watchdog
   import mul_seq_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - control stage for the iterative 64x64 multiplier
// Purpose: accepts operand pairs, runs the multiplier's start/clear
//          protocol, captures the product and hands it downstream, with a
//          watchdog timeout and a soft abort.
// Ports:   clk, reset_n (async active-low), abort (sync soft cancel),
//          bus (operand stream, multiplier link, result stream),
//          busy (state != IDLE). All outputs decode registered state only.
module mul_sequencer
   import mul_seq_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           abort,
   mul_sequencer_if.slave bus,
   output logic           busy
);

   state_e           state_q, state_d;
   logic [OP_W-1:0]  a_q, a_d;
   logic [OP_W-1:0]  b_q, b_d;
   logic [RES_W-1:0] result_q, result_d;
   logic             err_q, err_d;
   logic             discard_q, discard_d;

   logic             wd_clr;
   logic             wd_en;
   logic             wd_expire;

   mul_seq_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expire  (wd_expire)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      err_d     = err_q;
      discard_d = discard_q;
      wd_clr    = 1'b0;
      wd_en     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A cycle with abort high swallows the operand offer as well.
            if (bus.in_valid && !abort) begin
               a_d       = bus.in_multiplier;
               b_d       = bus.in_multiplicand;
               err_d     = 1'b0;
               discard_d = 1'b0;
               wd_clr    = 1'b1;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            wd_en = 1'b1;
            // Priority: abort, then done, then timeout (done on the
            // expiry cycle still counts as a good product).
            if (abort) begin
               discard_d = 1'b1;
               state_d   = ST_CLEAR;
            end else if (bus.mul_op_done) begin
               result_d = bus.mul_result;
               state_d  = ST_CLEAR;
            end else if (wd_expire) begin
               err_d    = 1'b1;
               result_d = '0;
               state_d  = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            // An abort landing in CLEAR cancels the hand-off right away.
            if (abort) begin
               discard_d = 1'b1;
            end
            state_d = (discard_q || abort) ? ST_IDLE : ST_OUT;
         end
         ST_OUT: begin
            if (abort || bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         result_q  <= '0;
         err_q     <= 1'b0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         result_q  <= result_d;
         err_q     <= err_d;
         discard_q <= discard_d;
      end
   end

   assign bus.in_ready         = (state_q == ST_IDLE);
   assign bus.mul_multiplier   = a_q;
   assign bus.mul_multiplicand = b_q;
   assign bus.mul_op_start     = (state_q == ST_RUN);
   assign bus.mul_op_clear     = (state_q == ST_CLEAR);
   assign bus.out_valid        = (state_q == ST_OUT);
   assign bus.out_result       = result_q;
   assign bus.out_err          = err_q;
   assign busy                 = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - self-checking bench for mul_sequencer
module tb_mul_sequencer;
   import mul_seq_pkg::*;

   localparam int TO = 10;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic abort   = 1'b0;
   logic busy;

   mul_sequencer_if bus();

   mul_sequencer #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .abort   (abort),
      .bus     (bus),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // Behavioural multiplier: after lat_cur start-cycles the product appears
   // and done holds until clear. lat_cur == 0 models a hung multiplier.
   int           lat_cur = 1;
   int           m_cnt;
   logic         m_done;
   logic [127:0] m_res;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_cnt  <= 0;
         m_done <= 1'b0;
         m_res  <= '0;
      end else if (bus.mul_op_clear) begin
         m_cnt  <= 0;
         m_done <= 1'b0;
      end else if (bus.mul_op_start && !m_done) begin
         if (lat_cur != 0 && m_cnt + 1 == lat_cur) begin
            m_done <= 1'b1;
            m_res  <= {64'd0, bus.mul_multiplier} * {64'd0, bus.mul_multiplicand};
         end
         m_cnt <= m_cnt + 1;
      end
   end

   assign bus.mul_op_done = m_done;
   assign bus.mul_result  = m_res;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [63:0]  a;
      logic [63:0]  b;
      int           lat;
      logic [127:0] res;
      logic         err;
   } vec_t;

   typedef struct {
      logic [127:0] res;
      logic         err;
   } exp_t;

   vec_t tbl[8];
   exp_t exp_q[$];

   // Called on a negedge while the sequencer is idle; returns on the
   // negedge right after the accepting edge.
   task automatic start_op(input logic [63:0] a, input logic [63:0] b, input int lat);
      lat_cur             = lat;
      bus.in_multiplier   = a;
      bus.in_multiplicand = b;
      bus.in_valid        = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic do_op(input logic [63:0] a, input logic [63:0] b, input int lat,
                        output logic [127:0] r, output logic e);
      int cyc;
      bus.out_ready = 1'b0;
      cyc = 0;
      while (!bus.in_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      start_op(a, b, lat);
      cyc = 0;
      while (!bus.out_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      r = bus.out_valid ? bus.out_result : 'x;
      e = bus.out_valid ? bus.out_err : 1'bx;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   // Watches 20 cycles after an abort edge for clear pulses and outputs.
   task automatic watch_abort(input string name);
      int n_clr = 0;
      int n_val = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         abort = 1'b0;
         if (bus.mul_op_clear) n_clr++;
         if (bus.out_valid) n_val++;
      end
      check({name, "_clr_pulses"}, n_clr, 1);
      check({name, "_out_valid"}, n_val, 0);
      check({name, "_busy"}, busy, 1'b0);
   endtask

   // Streams n_ops random operations through a scoreboard. Expected
   // results come from plain arithmetic and the rule that a product
   // arriving within TO run cycles is good, otherwise a timeout.
   task automatic run_stream(input int n_ops, input bit rnd);
      int          issued = 0;
      int          got    = 0;
      int          cyc    = 0;
      int          l;
      logic [63:0] a, b;
      exp_t        e;
      exp_q.delete();
      while ((issued < n_ops || got < n_ops) && cyc < 20000) begin
         bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("stream_extra_result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("stream_result", bus.out_result, e.res);
               check("stream_err", bus.out_err, e.err);
            end
            got++;
         end
         if (bus.in_ready && issued < n_ops) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 63);
            l = rnd ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 6));
            lat_cur             = l;
            bus.in_multiplier   = a;
            bus.in_multiplicand = b;
            bus.in_valid        = 1'b1;
            e.err = (l > TO - 1);
            e.res = e.err ? 128'd0 : {64'd0, a} * {64'd0, b};
            exp_q.push_back(e);
            issued++;
         end else if (bus.in_ready) begin
            bus.in_valid = 1'b0;
         end else if (rnd) begin
            bus.in_valid        = 1'($urandom_range(0, 1));
            bus.in_multiplier   = {$urandom, $urandom};
            bus.in_multiplicand = {$urandom, $urandom};
         end
         @(negedge clk);
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("stream_count", got, n_ops);
      check("stream_leftover", exp_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [127:0] r;
      logic         e;
      logic [127:0] held;
      int           cyc;
      int           n_run;
      int           n_unstable;
      bit           seen;

      tbl[0] = '{64'h101, 64'h784B, 3, 128'h78C34B, 1'b0};
      tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8,
                 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0};
      tbl[2] = '{64'd3, 64'd5, 1, 128'hF, 1'b0};
      tbl[3] = '{64'h1234, 64'h10, 9, 128'h12340, 1'b0};
      tbl[4] = '{64'h55, 64'h2, 10, 128'h0, 1'b1};
      tbl[5] = '{64'd7, 64'd7, 0, 128'h0, 1'b1};
      tbl[6] = '{64'h0, 64'hDEAD, 2, 128'h0, 1'b0};
      tbl[7] = '{64'h8000_0000_0000_0000, 64'd2, 4, 128'h1_0000_0000_0000_0000, 1'b0};

      bus.in_valid        = 1'b0;
      bus.in_multiplier   = '0;
      bus.in_multiplicand = '0;
      bus.out_ready       = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_err", bus.out_err, 1'b0);
      check("rst_op_start", bus.mul_op_start, 1'b0);
      check("rst_op_clear", bus.mul_op_clear, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);

      // Basic operation with latency checks
      bus.out_ready = 1'b1;
      check("basic_start_before", bus.mul_op_start, 1'b0);
      start_op(64'h101, 64'h784B, 3);
      check("basic_start_after", bus.mul_op_start, 1'b1);
      check("basic_in_ready_run", bus.in_ready, 1'b0);
      cyc = 0;
      while (!bus.mul_op_done && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("basic_done_seen", bus.mul_op_done, 1'b1);
      @(negedge clk);
      check("basic_clear_pulse", bus.mul_op_clear, 1'b1);
      check("basic_valid_early", bus.out_valid, 1'b0);
      @(negedge clk);
      check("basic_clear_width", bus.mul_op_clear, 1'b0);
      check("basic_valid", bus.out_valid, 1'b1);
      check("basic_result", bus.out_result, 128'h78C34B);
      check("basic_err", bus.out_err, 1'b0);
      @(negedge clk);
      check("basic_back_idle", bus.in_ready, 1'b1);
      bus.out_ready = 1'b0;

      // Back-pressure
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5);
      cyc = 0;
      while (!bus.out_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("bp_valid", bus.out_valid, 1'b1);
      held = bus.out_result;
      check("bp_result", held, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
      n_unstable = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b1 || bus.out_result !== held || bus.in_ready !== 1'b0)
            n_unstable++;
      end
      check("bp_stable_cycles_bad", n_unstable, 0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("bp_release_in_ready", bus.in_ready, 1'b1);

      // Watchdog timeout with a hung multiplier
      start_op(64'd9, 64'd9, 0);
      n_run = 0;
      cyc = 0;
      while (!bus.mul_op_clear && cyc < 50) begin
         if (bus.mul_op_start) n_run++;
         @(negedge clk);
         cyc++;
      end
      check("to_run_cycles", n_run, TO);
      @(negedge clk);
      check("to_valid", bus.out_valid, 1'b1);
      check("to_err", bus.out_err, 1'b1);
      check("to_result", bus.out_result, 128'h0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;

      // Abort alone in RUN
      start_op(64'd11, 64'd13, 6);
      @(negedge clk);
      abort = 1'b1;
      watch_abort("abort_run");

      // Abort on the same edge that first samples op_done
      start_op(64'd17, 64'd19, 2);
      seen = 1'b0;
      cyc = 0;
      while (!seen && cyc < 50) begin
         if (bus.mul_op_done) seen = 1'b1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      check("abort_done_seen", seen, 1'b1);
      abort = 1'b1;
      watch_abort("abort_done");

      // Abort while the result waits in OUT
      start_op(64'd21, 64'd23, 1);
      cyc = 0;
      while (!bus.out_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_out_valid", bus.out_valid, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_out_dropped", bus.out_valid, 1'b0);
      check("abort_out_idle", bus.in_ready, 1'b1);

      // Asynchronous reset mid-RUN
      start_op(64'd25, 64'd27, 8);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_op_start", bus.mul_op_start, 1'b0);
      check("arst_in_ready", bus.in_ready, 1'b1);
      check("arst_busy", busy, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      do_op(64'd3, 64'd5, 2, r, e);
      check("arst_after_result", r, 128'hF);
      check("arst_after_err", e, 1'b0);

      // Vector table
      for (int i = 0; i < 8; i++) begin
         do_op(tbl[i].a, tbl[i].b, tbl[i].lat, r, e);
         check($sformatf("tbl%0d_result", i), r, tbl[i].res);
         check($sformatf("tbl%0d_err", i), e, tbl[i].err);
      end

      // Back-to-back with in_valid held high, then randomized traffic
      run_stream(4, 1'b0);
      run_stream(40, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Upstream control stage for the 64x64 iterative `multiplier` block.
- Accepts operand pairs over a valid/ready handshake and latches them.
- Drives the multiplier's op_start/op_clear protocol and waits for op_done.
- Captures the 128-bit product, clears the multiplier, and presents the result downstream over a valid/ready handshake.
- Adds a watchdog timeout and a soft abort, so a hung or cancelled operation never wedges the datapath.

Parameters:
- TIMEOUT, 200: max cycles in RUN without op_done before an error is flagged (must be ≥ 2).
- CNT_W, 8: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous soft cancel of the current operation.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept operands.
- in_multiplier  in  64  operand A.
- in_multiplicand  in  64  operand B.
- mul_multiplier  out  64  to multiplier, held stable from accept to OUT exit.
- mul_multiplicand  out  64  to multiplier, held stable from accept to OUT exit.
- mul_op_start  out  1  to multiplier op_start.
- mul_op_clear  out  1  to multiplier op_clear.
- mul_op_done  in  1  from multiplier op_done; level, held until cleared.
- mul_result  in  128  from multiplier result.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts product.
- out_result  out  128  captured product.
- out_err  out  1  qualifies out_valid: 1 = watchdog timeout; out_result is 0 in that case.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, reset_n=0): state IDLE; operand regs, result reg, counter and err flag = 0.
  - Output values under reset: mul_op_start=0, mul_op_clear=0, out_valid=0, out_err=0, busy=0, in_ready=1.
- All outputs are decoded from registered state/regs only. No combinational path from any input to any output.
- States: IDLE, RUN, CLEAR, OUT.
- IDLE:
  - in_ready=1.
  - If in_valid=1 at edge T: latch both operands, counter←0, err←0, discard←0, go to RUN at T+1.
- RUN:
  - mul_op_start=1; counter increments every cycle.
  - mul_op_done=1: result←mul_result; go to CLEAR.
  - Else if counter==TIMEOUT-1: err←1; result←0; go to CLEAR.
- CLEAR:
  - mul_op_start=0, mul_op_clear=1 for exactly one cycle.
  - Next state is OUT, or IDLE if discard=1.
- OUT:
  - out_valid=1, out_result=result, out_err=err.
  - Holds stable until out_ready=1 at an edge, then goes to IDLE.
  - in_ready=0 while in OUT.
- Latency:
  - op_start rises 1 cycle after accept.
  - out_valid rises 2 cycles after the first edge that samples mul_op_done=1.
  - Best-case throughput: accept → OUT → accept, gated by multiplier latency + 3 cycles.
- Abort (highest priority, sampled at edge):
  - IDLE: ignored; in_valid is also ignored that cycle.
  - RUN: discard←1, go to CLEAR. Multiplier is cleared; no out_valid.
  - CLEAR: discard←1.
  - OUT: result dropped, go to IDLE.
  - abort and mul_op_done in the same cycle: abort wins; product discarded.
- Simultaneous done and timeout in the same cycle: done wins, err=0.
- mul_op_done seen outside RUN: ignored.
- Reset mid-operation: immediate return to the reset values above. The multiplier shares reset_n and needs no clear.
- No arithmetic is done here; the product width is 128 bits, passed through unmodified.

Decomposition:
- Package mul_seq_pkg holds:
  - the state encoding (2-bit: IDLE=0, RUN=1, CLEAR=2, OUT=3);
  - operand width 64 and result width 128 as constants;
  - the default TIMEOUT.
- One sub-module: mul_seq_watchdog.
  - Holds the CNT_W counter with clear/enable inputs.
  - Produces an expire output when count==TIMEOUT-1.
- The FSM and data registers stay in mul_sequencer.

Test Plan:
- Basic: operands 0x101 × 0x784B with the real multiplier, out_ready=1 → out_valid with out_result=0x78C34B and out_err=0; mul_op_clear high exactly 1 cycle; op_start rises 1 cycle after accept.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid → out_result stable, in_ready=0 throughout; then out_ready=1 → in_ready=1 the next cycle. Then 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- Timeout: behavioural multiplier stub that never asserts op_done, TIMEOUT=10 → CLEAR entered after 10 RUN cycles; out_valid with out_err=1 and out_result=0.
- Abort: assert abort in RUN, once alone and once in the same cycle as op_done → one op_clear pulse; returns to IDLE; out_valid never asserts.
- Reset mid-RUN: drop reset_n asynchronously between clock edges → mul_op_start=0 immediately, in_ready=1, busy=0. A subsequent 3 × 5 operation completes with 0xF.
- Back-to-back: 4 operand pairs with in_valid held high → 4 results in order, and none is dropped or duplicated.
